// File: rtl/memory_issue_split_pkg.sv
// Shared definitions for the memory issue stage: FSM states, beat kinds and
// small constant helpers used to size and classify accesses.
package memory_issue_split_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat0 = 2'd1,
    StBeat1 = 2'd2
  } state_t;

  // Which half of a (possibly split) access the lane aligner should produce.
  localparam logic BEAT_LOWER = 1'b0;
  localparam logic BEAT_UPPER = 1'b1;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned log2_int(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // An access needs two beats when its last byte falls past the word end.
  function automatic logic crosses_word(input int unsigned offset,
                                        input int unsigned log2_bytes,
                                        input int unsigned num_bytes);
    return (offset + (32'd1 << log2_bytes)) > num_bytes;
  endfunction

endpackage

// File: rtl/memory_issue_split_memory_lane_align.sv
// Combinational lane steering for one beat of a memory access: byte enables,
// shifted store data and whether the access spans two words.
module memory_lane_align
  import memory_issue_split_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_BYTES      = DATA_WIDTH / 8,
  parameter int unsigned LOG2_NUM_BYTES = log2_int(NUM_BYTES)
) (
  input  logic [LOG2_NUM_BYTES-1:0] offset,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  input  logic                      beat,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic [NUM_BYTES-1:0]      byte_en,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      split
);

  logic [LOG2_NUM_BYTES:0] size;
  logic [LOG2_NUM_BYTES:0] rev;
  logic [NUM_BYTES:0]      mask;

  // Lower beat shifts the access up by offset; upper beat takes what spilled over.
  always_comb begin
    size = (LOG2_NUM_BYTES + 1)'(1) << log2_bytes;
    // One spare bit so a full-word mask does not overflow.
    mask = ((NUM_BYTES + 1)'(1) << size) - (NUM_BYTES + 1)'(1);
    rev  = (LOG2_NUM_BYTES + 1)'(NUM_BYTES) - {1'b0, offset};
    byte_en = '0;
    data    = '0;
    if (beat == BEAT_UPPER) begin
      byte_en = NUM_BYTES'(mask >> rev);
      data    = store_data >> {rev, 3'b000};
    end else begin
      byte_en = NUM_BYTES'(mask << offset);
      data    = store_data << {offset, 3'b000};
    end
    split = crosses_word(32'(offset), 32'(log2_bytes), NUM_BYTES);
  end

endmodule

// File: rtl/memory_issue_split.sv
// Registered memory issue stage: accepts one load/store per handshake, splits
// word-crossing accesses into two aligned beats and holds each beat until the
// memory accepts it.
module memory_issue_split
  import memory_issue_split_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_BITS   = 20,
  parameter int unsigned NUM_BYTES      = DATA_WIDTH / 8,
  parameter int unsigned LOG2_NUM_BYTES = log2_int(NUM_BYTES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      store,
  input  logic [ADDRESS_BITS-1:0]   address,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  output logic                      req_ready,
  output logic                      memory_read,
  output logic                      memory_write,
  output logic [NUM_BYTES-1:0]      memory_byte_en,
  output logic [ADDRESS_BITS-1:0]   memory_address,
  output logic [DATA_WIDTH-1:0]     memory_data,
  input  logic                      memory_ready,
  output logic [LOG2_NUM_BYTES-1:0] load_offset,
  output logic                      load_second,
  output logic                      error,
  output logic [31:0]               split_count
);

  state_t                    state_q;
  logic [ADDRESS_BITS-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [LOG2_NUM_BYTES-1:0] log2_q;
  logic                      is_load_q;
  logic                      error_q;
  logic [31:0]               split_count_q;

  logic                      bad_size;
  logic                      illegal;
  logic                      accept;
  logic                      req_split;
  logic                      final_beat;
  logic                      beat_sel;
  logic                      beat_split;
  logic [NUM_BYTES-1:0]      beat_byte_en;
  logic [DATA_WIDTH-1:0]     beat_data;
  logic [ADDRESS_BITS-1:0]   base_addr;

  memory_lane_align #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_BYTES      (NUM_BYTES),
    .LOG2_NUM_BYTES (LOG2_NUM_BYTES)
  ) u_lane_align (
    .offset     (addr_q[LOG2_NUM_BYTES-1:0]),
    .log2_bytes (log2_q),
    .beat       (beat_sel),
    .store_data (data_q),
    .byte_en    (beat_byte_en),
    .data       (beat_data),
    .split      (beat_split)
  );

  // Handshake decode: a new request may land on the cycle the last beat retires.
  always_comb begin
    beat_sel   = (state_q == StBeat1) ? BEAT_UPPER : BEAT_LOWER;
    final_beat = (state_q == StBeat1) || ((state_q == StBeat0) && !beat_split);
    req_ready  = !reset && ((state_q == StIdle) || (final_beat && memory_ready));
    bad_size   = 32'(log2_bytes) > LOG2_NUM_BYTES;
    illegal    = req_ready && ((load && store) || ((load || store) && bad_size));
    accept     = req_ready && (load ^ store) && !bad_size;
    req_split  = crosses_word(32'(address[LOG2_NUM_BYTES-1:0]), 32'(log2_bytes), NUM_BYTES);
  end

  // FSM, request capture, error pulse and saturating split counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      data_q        <= '0;
      log2_q        <= '0;
      is_load_q     <= 1'b0;
      error_q       <= 1'b0;
      split_count_q <= '0;
    end else begin
      error_q <= illegal;
      if (accept) begin
        state_q   <= StBeat0;
        addr_q    <= address;
        data_q    <= store_data;
        log2_q    <= log2_bytes;
        is_load_q <= load;
        if (req_split && (split_count_q != '1)) split_count_q <= split_count_q + 32'd1;
      end else if ((state_q == StBeat0) && memory_ready) begin
        state_q <= beat_split ? StBeat1 : StIdle;
      end else if ((state_q == StBeat1) && memory_ready) begin
        state_q <= StIdle;
      end
    end
  end

  // Memory-side outputs decode purely from registered state, so they hold while stalled.
  always_comb begin
    base_addr      = {addr_q[ADDRESS_BITS-1:LOG2_NUM_BYTES], {LOG2_NUM_BYTES{1'b0}}};
    memory_read    = (state_q != StIdle) && is_load_q;
    memory_write   = (state_q != StIdle) && !is_load_q;
    memory_byte_en = '0;
    memory_address = '0;
    memory_data    = '0;
    load_offset    = '0;
    load_second    = 1'b0;
    if (state_q != StIdle) begin
      memory_byte_en = beat_byte_en;
      // Upper beat wraps modulo the address space.
      memory_address = (state_q == StBeat1) ? base_addr + ADDRESS_BITS'(NUM_BYTES) : base_addr;
    end
    if (memory_write) memory_data = beat_data;
    if (memory_read) begin
      load_offset = addr_q[LOG2_NUM_BYTES-1:0];
      load_second = (state_q == StBeat1);
    end
    error       = error_q;
    split_count = split_count_q;
  end

endmodule
